// File: rtl/fetch_decode_frontend_if.sv
// Handshake bundle between the fetch/decode front end, instruction memory,
// the redirect source and the execute stage.
interface fetch_decode_frontend_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 15
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               dec_valid;
  logic               dec_ready;
  logic [PC_W-1:0]    dec_pc;
  logic [5:0]         dec_opcode;
  logic [4:0]         dec_rs;
  logic [4:0]         dec_rt;
  logic [4:0]         dec_rd;
  logic [5:0]         dec_funct;
  logic [31:0]        dec_imm;
  logic [ADDR_W-1:0]  dec_address;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_pc, dec_opcode, dec_rs, dec_rt, dec_rd, dec_funct, dec_imm, dec_address,
    input  dec_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_pc, dec_opcode, dec_rs, dec_rt, dec_rd, dec_funct, dec_imm, dec_address,
    output dec_ready
  );
endinterface

// File: rtl/fetch_decode_frontend.sv
// Instruction front end: PC generation, single-outstanding imem fetch, DEPTH-entry
// instruction FIFO and zero-latency field decode from the FIFO head, with redirect flush.
module fetch_decode_frontend #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              ADDR_W   = 15,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  fetch_decode_frontend_if.master fd
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t           state, state_nx;
  logic [PC_W-1:0]  pc, pc_nx, req_pc;
  entry_t           fifo_mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             xfer, push, pop, space, valid;

  // Only IDLE issues, so nothing is outstanding when the space check is made.
  assign space        = count < CNT_W'(DEPTH);
  assign fd.imem_req  = reset_n & (state == IDLE) & space & ~fd.redirect_valid;
  assign fd.imem_addr = pc;
  assign xfer         = fd.imem_req & fd.imem_gnt;
  assign push         = (state == WAIT) & fd.imem_rvalid & ~fd.redirect_valid;
  assign pop          = valid & fd.dec_ready & ~fd.redirect_valid;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    if (fd.redirect_valid) begin
      pc_nx = fd.redirect_pc;
      // A response landing with the redirect closes the old request; only an unanswered one needs dropping.
      state_nx = (xfer || (state != IDLE && !fd.imem_rvalid)) ? DROP : IDLE;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          state_nx = WAIT;
          pc_nx    = pc + PC_W'(4);
        end
        WAIT, DROP: if (fd.imem_rvalid) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (xfer) req_pc <= pc;
      if (fd.redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {req_pc, fd.imem_rdata};
  end

  assign valid = (count != '0);

  always_comb begin
    head           = fifo_mem[rd_ptr];
    fd.dec_valid   = valid;
    fd.dec_pc      = '0;
    fd.dec_opcode  = '0;
    fd.dec_rs      = '0;
    fd.dec_rt      = '0;
    fd.dec_rd      = '0;
    fd.dec_funct   = '0;
    fd.dec_imm     = '0;
    fd.dec_address = '0;
    if (valid) begin
      fd.dec_pc      = head.pc;
      fd.dec_opcode  = head.instr[31:26];
      fd.dec_rs      = head.instr[25:21];
      fd.dec_rt      = head.instr[20:16];
      fd.dec_rd      = head.instr[15:11];
      fd.dec_funct   = head.instr[5:0];
      fd.dec_imm     = {{16{head.instr[15]}}, head.instr[15:0]};
      fd.dec_address = head.instr[ADDR_W-1:0];
    end
  end
endmodule
